// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD picture path.
//   - MIPI-DCS command codes used to open a drawing window
//   - RGB565 colour constants
//   - FSM state type of lcd_stream_pic
//   - clip_span(): clips a 1-D window extent against the panel size
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic [15:0] COLOR_BLACK = 16'h0000;
  localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
  localparam logic [15:0] COLOR_RED   = 16'hF800;
  localparam logic [15:0] COLOR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE  = 16'h001F;

  // Number of bytes in the CASET/RASET/RAMWR preamble.
  localparam int CMD_SEQ_LEN = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_FETCH = 3'd2,
    ST_LATCH = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } lcd_state_e;

  // Visible extent of a window starting at org with the requested size,
  // given a panel dimension res. An origin outside the panel gives 0.
  function automatic logic [9:0] clip_span(input logic [9:0] org,
                                           input logic [9:0] size,
                                           input logic [9:0] res);
    logic [9:0] room;
    clip_span = 10'd0;
    room      = 10'd0;
    if (org < res) begin
      room      = res - org;
      clip_span = (size < room) ? size : room;
    end
  endfunction

endpackage

// File: rtl/lcd_win_cmd_seq.sv
// lcd_win_cmd_seq: combinational lookup of the 11-byte window preamble.
//   i_idx          : byte index 0..10
//   i_xs/i_xe      : column start/end address
//   i_ys/i_ye      : row start/end address
//   o_byte         : {is_data, byte}; bit 8 = 0 for command, 1 for parameter
module lcd_win_cmd_seq
  import lcd_pkg::*;
(
  input  logic [3:0]  i_idx,
  input  logic [15:0] i_xs,
  input  logic [15:0] i_xe,
  input  logic [15:0] i_ys,
  input  logic [15:0] i_ye,
  output logic [8:0]  o_byte
);

  always_comb begin
    o_byte = 9'h000;
    case (i_idx)
      4'd0:    o_byte = {1'b0, CMD_CASET};
      4'd1:    o_byte = {1'b1, i_xs[15:8]};
      4'd2:    o_byte = {1'b1, i_xs[7:0]};
      4'd3:    o_byte = {1'b1, i_xe[15:8]};
      4'd4:    o_byte = {1'b1, i_xe[7:0]};
      4'd5:    o_byte = {1'b0, CMD_RASET};
      4'd6:    o_byte = {1'b1, i_ys[15:8]};
      4'd7:    o_byte = {1'b1, i_ys[7:0]};
      4'd8:    o_byte = {1'b1, i_ye[15:8]};
      4'd9:    o_byte = {1'b1, i_ye[7:0]};
      4'd10:   o_byte = {1'b0, CMD_RAMWR};
      default: o_byte = 9'h000;
    endcase
  end

endmodule

// File: rtl/lcd_stream_pic.sv
// lcd_stream_pic: streams a (possibly partial) picture from the UART RX FIFO
// to the shared LCD byte-write engine.
//   sys_clk, sys_rst     : clock, synchronous active-high reset
//   start, abort         : transfer start pulse / synchronous abort
//   win_x/y/w/h          : window origin and size, sampled on accepted start
//   fifo_cnt/rd_en/q     : FIFO fill level, read pulse, read data (1-cycle latency)
//   wr_data/wr_en/done   : byte to writer (bit 8 = data), write request, writer ack
//   busy, done, err      : activity, completion pulse, sticky timeout flag
// Optional feature macro: LCD_PIC_TIMEOUT_EN enables the FIFO starvation
// timeout and the err flag; without it err is constant 0.
module lcd_stream_pic
  import lcd_pkg::*;
#(
  parameter int H_RES         = 240,
  parameter int V_RES         = 320,
  parameter int BYTES_PER_PIX = 2,
  parameter int FIFO_CNT_W    = 10,
  parameter int TIMEOUT_CYC   = 1_000_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [8:0]            win_x,
  input  logic [8:0]            win_y,
  input  logic [8:0]            win_w,
  input  logic [8:0]            win_h,
  input  logic [FIFO_CNT_W-1:0] fifo_cnt,
  output logic                  fifo_rd_en,
  input  logic [7:0]            fifo_q,
  output logic [8:0]            wr_data,
  output logic                  wr_en,
  input  logic                  wr_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [9:0] H_RES_10  = 10'(H_RES);
  localparam logic [9:0] V_RES_10  = 10'(V_RES);
  localparam logic [1:0] BYTE_LAST = 2'(BYTES_PER_PIX - 1);
  localparam logic [3:0] CMD_LAST  = 4'(CMD_SEQ_LEN - 1);

  lcd_state_e r_state, w_state_next;

  logic [9:0] r_xs, r_xe, r_ys, r_ye;
  logic [9:0] r_col_last, r_row_last;
  logic [9:0] r_col, r_row;
  logic [1:0] r_byte_idx;
  logic [3:0] r_cmd_idx;
  logic       r_issue;     // high for exactly the first cycle of each write
  logic [8:0] r_wr_data;

  logic [9:0] w_clip_w, w_clip_h;
  logic       w_empty_win, w_start_ok, w_last_byte, w_cmd_last, w_fifo_empty;
  logic       w_timeout;
  logic [8:0] w_cmd_byte;

  assign w_clip_w     = clip_span({1'b0, win_x}, {1'b0, win_w}, H_RES_10);
  assign w_clip_h     = clip_span({1'b0, win_y}, {1'b0, win_h}, V_RES_10);
  assign w_empty_win  = (w_clip_w == 10'd0) || (w_clip_h == 10'd0);
  assign w_start_ok   = start && !abort && (r_state == ST_IDLE);
  assign w_cmd_last   = (r_cmd_idx == CMD_LAST);
  assign w_fifo_empty = (fifo_cnt == '0);
  assign w_last_byte  = (r_byte_idx == BYTE_LAST) && (r_col == r_col_last) &&
                        (r_row == r_row_last);

  lcd_win_cmd_seq u_cmd_seq (
    .i_idx  (r_cmd_idx),
    .i_xs   ({6'd0, r_xs}),
    .i_xe   ({6'd0, r_xe}),
    .i_ys   ({6'd0, r_ys}),
    .i_ye   ({6'd0, r_ye}),
    .o_byte (w_cmd_byte)
  );

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_state_next = w_empty_win ? ST_DONE : ST_CMD;
        ST_CMD:   if (wr_done && w_cmd_last) w_state_next = ST_FETCH;
        ST_FETCH: begin
          if (!w_fifo_empty)  w_state_next = ST_LATCH;
          else if (w_timeout) w_state_next = ST_IDLE;
        end
        ST_LATCH: w_state_next = ST_WRITE;
        ST_WRITE: if (wr_done) w_state_next = w_last_byte ? ST_DONE : ST_FETCH;
        ST_DONE:  w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs. DONE is treated as not busy so busy falls with the done pulse.
  // The request strobes are gated by abort so nothing leaves in the abort cycle.
  always_comb begin
    busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    done       = (r_state == ST_DONE) && !abort;
    fifo_rd_en = (r_state == ST_FETCH) && !w_fifo_empty && !abort;
    wr_en      = r_issue && !abort && ((r_state == ST_CMD) || (r_state == ST_WRITE));
    // During CMD the byte comes straight from the table; the index only moves
    // on wr_done, so the value is held for the whole write.
    wr_data    = (r_state == ST_CMD) ? w_cmd_byte : r_wr_data;
  end

  // Window latch, preamble index, pixel counters and write strobe.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_xs       <= 10'd0;
      r_xe       <= 10'd0;
      r_ys       <= 10'd0;
      r_ye       <= 10'd0;
      r_col_last <= 10'd0;
      r_row_last <= 10'd0;
      r_col      <= 10'd0;
      r_row      <= 10'd0;
      r_byte_idx <= 2'd0;
      r_cmd_idx  <= 4'd0;
      r_issue    <= 1'b0;
      r_wr_data  <= 9'h000;
    end else begin
      r_issue <= 1'b0;
      if (abort) begin
        r_col      <= 10'd0;
        r_row      <= 10'd0;
        r_byte_idx <= 2'd0;
        r_cmd_idx  <= 4'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_xs       <= {1'b0, win_x};
              r_xe       <= {1'b0, win_x} + w_clip_w - 10'd1;
              r_ys       <= {1'b0, win_y};
              r_ye       <= {1'b0, win_y} + w_clip_h - 10'd1;
              r_col_last <= w_clip_w - 10'd1;
              r_row_last <= w_clip_h - 10'd1;
              r_col      <= 10'd0;
              r_row      <= 10'd0;
              r_byte_idx <= 2'd0;
              r_cmd_idx  <= 4'd0;
              r_issue    <= !w_empty_win;
            end
          end
          ST_CMD: begin
            if (wr_done && !w_cmd_last) begin
              r_cmd_idx <= r_cmd_idx + 4'd1;
              r_issue   <= 1'b1;
            end
          end
          ST_LATCH: begin
            r_wr_data <= {1'b1, fifo_q};
            r_issue   <= 1'b1;
          end
          ST_WRITE: begin
            if (wr_done) begin
              // byte_idx carries into col, col carries into row.
              if (r_byte_idx == BYTE_LAST) begin
                r_byte_idx <= 2'd0;
                if (r_col == r_col_last) begin
                  r_col <= 10'd0;
                  r_row <= r_row + 10'd1;
                end else begin
                  r_col <= r_col + 10'd1;
                end
              end else begin
                r_byte_idx <= r_byte_idx + 2'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LCD_PIC_TIMEOUT_EN
  // Wide enough to hold TIMEOUT_CYC itself for any parameter value.
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign w_timeout = (r_state == ST_FETCH) && w_fifo_empty &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign err       = r_err;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == ST_FETCH) && w_fifo_empty && !abort) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                                                  r_to_cnt <= '0;
      if (w_start_ok)                r_err <= 1'b0;
      else if (w_timeout && !abort)  r_err <= 1'b1;
    end
  end
`else
  logic w_unused_to;

  assign w_timeout   = 1'b0;
  assign err         = 1'b0;
  assign w_unused_to = ^{TIMEOUT_CYC, w_start_ok};
`endif

endmodule

// File: tb/tb_lcd_stream_pic.sv
module tb_lcd_stream_pic;

  localparam int H_RES  = 240;
  localparam int V_RES  = 320;
  localparam int BPP    = 2;
  localparam int CW     = 10;
  localparam int TO_CYC = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst, start, abort;
  logic [8:0]    win_x, win_y, win_w, win_h;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_rd_en;
  logic [7:0]    fifo_q;
  logic [8:0]    wr_data;
  logic          wr_en, wr_done, busy, done, err;

  always #5 sys_clk = ~sys_clk;

  lcd_stream_pic #(
    .H_RES(H_RES), .V_RES(V_RES), .BYTES_PER_PIX(BPP),
    .FIFO_CNT_W(CW), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
    .fifo_cnt(fifo_cnt), .fifo_rd_en(fifo_rd_en), .fifo_q(fifo_q),
    .wr_data(wr_data), .wr_en(wr_en), .wr_done(wr_done),
    .busy(busy), .done(done), .err(err)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] fifo_mem[$];
  int         exp_done = 0;
  int         done_seen = 0;
  int         wr_cnt = 0;
  bit         hold = 0;
  bit         outstanding = 0;
  logic [8:0] cur_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Reference window clip, straight from the rules in plain integers.
  function automatic int clip(input int o, input int s, input int res);
    if (o >= res) return 0;
    if (s < res - o) return s;
    return res - o;
  endfunction

  // Environment: FIFO with 1-cycle read latency and a writer with random ack delay.
  initial begin : env
    bit s_rd, s_wr, pend;
    int dly;
    wr_done = 1'b0; fifo_q = 8'h00; fifo_cnt = '0; pend = 0; dly = 0;
    forever begin
      @(negedge sys_clk);
      s_rd = fifo_rd_en;
      s_wr = wr_en;
      @(posedge sys_clk);
      #1;
      wr_done = 1'b0;
      if (s_rd && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
      if (s_wr) begin
        pend = 1;
        dly  = $urandom_range(1, 3);
      end
      if (pend) begin
        dly--;
        if (dly == 0) begin
          wr_done = 1'b1;
          pend    = 0;
        end
      end
      fifo_cnt = hold ? '0 : CW'((fifo_mem.size() > 1023) ? 1023 : fifo_mem.size());
    end
  end

  // Monitor / scoreboard.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (wr_en) begin
        check("one_outstanding", 32'(outstanding), 0);
        check("wr_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur_exp = exp_q.pop_front();
          check("wr_data", 32'(wr_data), 32'(cur_exp));
        end
        outstanding = 1;
        wr_cnt++;
      end
      if (wr_done && outstanding) begin
        check("wr_data_stable", 32'(wr_data), 32'(cur_exp));
        outstanding = 0;
      end
      if (done) begin
        check("done_expected", int'(exp_done > 0), 1);
        check("done_queue_drained", exp_q.size(), 0);
        check("done_not_busy", 32'(busy), 0);
        if (exp_done > 0) exp_done--;
        done_seen++;
      end
    end
  end

  task automatic push_word(input int v);
    logic [15:0] w16;
    w16 = 16'(v);
    exp_q.push_back({1'b1, w16[15:8]});
    exp_q.push_back({1'b1, w16[7:0]});
  endtask

  // Queue the expected response for a window, feed the FIFO, pulse start.
  task automatic launch(input int x, input int y, input int w, input int h,
                        input int feed_max, output int n_bytes);
    int wc, hc;
    logic [7:0] b;
    wc = clip(x, w, H_RES);
    hc = clip(y, h, V_RES);
    n_bytes = wc * hc * BPP;
    if (n_bytes > 0) begin
      exp_q.push_back(9'h02A);
      push_word(x);
      push_word(x + wc - 1);
      exp_q.push_back(9'h02B);
      push_word(y);
      push_word(y + hc - 1);
      exp_q.push_back(9'h02C);
    end
    for (int i = 0; i < n_bytes && i < feed_max; i++) begin
      b = 8'($urandom);
      fifo_mem.push_back(b);
      exp_q.push_back({1'b1, b});
    end
    exp_done++;
    wr_cnt = 0;
    win_x = 9'(x); win_y = 9'(y); win_w = 9'(w); win_h = 9'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int c = 0; c < budget && exp_done != 0; c++) tick();
    check(name, exp_done, 0);
  endtask

  task automatic wait_wr(input string name, input int target, input int budget);
    for (int c = 0; c < budget && wr_cnt < target; c++) tick();
    check(name, wr_cnt, target);
  endtask

  task automatic flush();
    exp_q.delete();
    fifo_mem.delete();
    exp_done = 0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n, d0, w0, sel, x, y;
    sys_rst = 1'b1; start = 1'b0; abort = 1'b0;
    win_x = '0; win_y = '0; win_w = '0; win_h = '0;
    tick(3);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    tick();

    // Full screen preamble, then abort during pixel byte 5.
    launch(0, 0, 240, 320, 16, n);
    @(negedge sys_clk);
    check("start_to_wr_en", 32'(wr_en), 1);
    check("start_busy", 32'(busy), 1);
    tick();
    wait_wr("abort_reach", 11 + 6, 3000);
    abort = 1'b1;
    flush();
    d0 = done_seen;
    @(negedge sys_clk);
    check("abort_wr_en", 32'(wr_en), 0);
    check("abort_rd_en", 32'(fifo_rd_en), 0);
    tick();
    abort = 1'b0;
    @(negedge sys_clk);
    check("abort_idle", 32'(busy), 0);
    check("abort_wr_en_next", 32'(wr_en), 0);
    tick(8);
    check("abort_no_done", done_seen, d0);

    // Restart replays the preamble from 02A.
    launch(5, 7, 3, 2, 1000, n);
    @(negedge sys_clk);
    check("restart_wr_en", 32'(wr_en), 1);
    check("restart_first_cmd", 32'(wr_data), 32'h02A);
    tick();
    wait_done("restart_done", 2000);
    check("restart_count", wr_cnt, 11 + n);

    // Zero-size windows: done one cycle after start, no writes.
    launch(10, 10, 0, 5, 1000, n);
    @(negedge sys_clk);
    check("zero_done", 32'(done), 1);
    check("zero_wr_en", 32'(wr_en), 0);
    tick();
    launch(240, 0, 5, 5, 1000, n);
    @(negedge sys_clk);
    check("offpanel_done", 32'(done), 1);
    tick(3);
    check("zero_no_writes", wr_cnt, 0);

    // Clipped corner window; a start while busy must be ignored.
    launch(230, 310, 20, 20, 1000, n);
    tick(20);
    win_x = 9'd0; win_y = 9'd0; win_w = 9'd1; win_h = 9'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("clip_done", 5000);
    check("clip_count", wr_cnt, 11 + 200);

    // Abort and start together in IDLE: abort wins.
    win_x = 9'd1; win_y = 9'd1; win_w = 9'd4; win_h = 9'd4;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge sys_clk);
    check("abort_start_idle", 32'(busy), 0);
    check("abort_start_wr_en", 32'(wr_en), 0);
    tick();

    // Random windows, biased toward the clipping edges.
    for (int it = 0; it < 12; it++) begin
      sel = $urandom_range(0, 2);
      x = (sel == 0) ? $urandom_range(228, 250) : $urandom_range(0, 200);
      y = (sel == 1) ? $urandom_range(308, 330) : $urandom_range(0, 300);
      launch(x, y, $urandom_range(0, 10), $urandom_range(0, 10), 1000, n);
      wait_done("rand_done", 6000);
      check("rand_count", wr_cnt, (n > 0) ? 11 + n : 0);
      tick();
    end

    // FIFO starvation mid-row.
    launch(20, 30, 12, 4, 1000, n);
    wait_wr("starve_reach", 11 + 7, 2000);
    hold = 1;
    w0 = wr_cnt;
    d0 = done_seen;
`ifdef LCD_PIC_TIMEOUT_EN
    tick(TO_CYC + 8);
    @(negedge sys_clk);
    check("timeout_err", 32'(err), 1);
    check("timeout_idle", 32'(busy), 0);
    check("timeout_no_done", done_seen, d0);
    check("timeout_no_wr", wr_cnt, w0);
    tick();
    hold = 0;
    flush();
    tick(6);
    launch(3, 3, 2, 2, 1000, n);
    @(negedge sys_clk);
    check("err_cleared", 32'(err), 0);
    tick();
    wait_done("after_timeout_done", 2000);
`else
    tick(50);
    @(negedge sys_clk);
    check("starve_no_wr", wr_cnt, w0);
    check("starve_busy", 32'(busy), 1);
    tick();
    hold = 0;
    wait_done("starve_done", 3000);
    check("starve_count", wr_cnt, 11 + n);
    check("err_const", 32'(err), 0);
`endif

    tick(5);
    check("final_queue", exp_q.size(), 0);
    check("final_done", exp_done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
